// File: rtl/router_pkt_fifo_if.sv
// rtl/router_pkt_fifo_if.sv - write/read/status bundle for the packet-aware channel FIFO
interface router_pkt_fifo_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
);
   logic                   write_enb;
   logic                   lfd_state;
   logic [DATA_W-1:0]      data_in;
   logic                   read_enb;
   logic [DATA_W-1:0]      data_out;
   logic                   data_valid;
   logic                   pkt_active;
   logic                   pkt_done;
   logic                   empty;
   logic                   full;
   logic                   almost_full;
   logic [$clog2(DEPTH):0] count;
   logic                   ovf_err;
   logic                   udf_err;

   modport master (
      output write_enb, lfd_state, data_in, read_enb,
      input  data_out, data_valid, pkt_active, pkt_done,
      input  empty, full, almost_full, count, ovf_err, udf_err
   );

   modport slave (
      input  write_enb, lfd_state, data_in, read_enb,
      output data_out, data_valid, pkt_active, pkt_done,
      output empty, full, almost_full, count, ovf_err, udf_err
   );
endinterface

// File: rtl/router_pkt_fifo.sv
// rtl/router_pkt_fifo.sv - parametrised packet-aware router channel FIFO
module router_pkt_fifo #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int LEN_LSB   = 2,
   parameter int LEN_W     = 6,
   parameter int AF_MARGIN = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             soft_reset,
   router_pkt_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [LEN_W:0] REM_ONE = (LEN_W+1)'(1);

   logic [DATA_W:0]   mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     occ;
   logic [LEN_W:0]    rem_cnt;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              pkt_done;
   logic              ovf_err;
   logic              udf_err;

   logic              empty;
   logic              full;
   logic              wr_ok;
   logic              rd_ok;
   logic [DATA_W:0]   rd_word;
   logic [LEN_W-1:0]  rd_len;

   assign empty   = (occ == '0);
   assign full    = (occ == CW'(DEPTH));
   assign wr_ok   = bus.write_enb && !full;
   assign rd_ok   = bus.read_enb && !empty;
   assign rd_word = mem[rd_ptr];
   assign rd_len  = rd_word[LEN_LSB+LEN_W-1:LEN_LSB];

   // Storage is never cleared; a flushed channel simply forgets its pointers.
   always_ff @(posedge clk) begin
      if (resetn && !soft_reset && wr_ok)
         mem[wr_ptr] <= {bus.lfd_state, bus.data_in};
   end

   always_ff @(posedge clk) begin
      if (!resetn || soft_reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         occ        <= '0;
         rem_cnt    <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         pkt_done   <= 1'b0;
         ovf_err    <= 1'b0;
         udf_err    <= 1'b0;
      end else begin
         data_valid <= rd_ok;
         pkt_done   <= 1'b0;
         ovf_err    <= ovf_err | (bus.write_enb & full);
         udf_err    <= udf_err | (bus.read_enb & empty);

         if (wr_ok)
            wr_ptr <= wr_ptr + 1'b1;

         if (rd_ok) begin
            rd_ptr   <= rd_ptr + 1'b1;
            data_out <= rd_word[DATA_W-1:0];
            // A header always reloads, so a truncated packet never reports done.
            if (rd_word[DATA_W]) begin
               rem_cnt <= (LEN_W+1)'(rd_len) + REM_ONE;
            end else if (rem_cnt != '0) begin
               rem_cnt  <= rem_cnt - REM_ONE;
               pkt_done <= (rem_cnt == REM_ONE);
            end
         end

         case ({wr_ok, rd_ok})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   assign bus.data_out    = data_out;
   assign bus.data_valid  = data_valid;
   assign bus.pkt_active  = (rem_cnt != '0);
   assign bus.pkt_done    = pkt_done;
   assign bus.empty       = empty;
   assign bus.full        = full;
   assign bus.almost_full = (occ >= CW'(DEPTH - AF_MARGIN));
   assign bus.count       = occ;
   assign bus.ovf_err     = ovf_err;
   assign bus.udf_err     = udf_err;
endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb/tb_router_pkt_fifo.sv - directed and random checks of router_pkt_fifo against a queue model
module tb_router_pkt_fifo;
   localparam int DATA_W    = 8;
   localparam int DEPTH     = 16;
   localparam int LEN_LSB   = 2;
   localparam int LEN_W     = 6;
   localparam int AF_MARGIN = 2;

   logic clk;
   logic resetn;
   logic soft_reset;

   router_pkt_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   router_pkt_fifo #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_LSB(LEN_LSB), .LEN_W(LEN_W), .AF_MARGIN(AF_MARGIN)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .soft_reset(soft_reset),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: stored words as {tag, data}, plus the observable output state.
   logic [DATA_W:0] q[$];
   logic [7:0]      m_dout;
   bit              m_dv, m_done, m_ovf, m_udf;
   int              m_rem;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      q.delete();
      m_dout = '0; m_dv = 0; m_done = 0; m_ovf = 0; m_udf = 0; m_rem = 0;
   endtask

   task automatic model_edge(input bit we, input bit lfd, input logic [7:0] din, input bit re);
      logic [DATA_W:0] w;
      bit is_full, is_empty;
      if (!resetn || soft_reset) begin
         model_clear();
         return;
      end
      is_full  = (q.size() == DEPTH);
      is_empty = (q.size() == 0);
      if (we && is_full)  m_ovf = 1;
      if (re && is_empty) m_udf = 1;
      m_dv   = re && !is_empty;
      m_done = 0;
      if (m_dv) begin
         w      = q.pop_front();
         m_dout = w[7:0];
         if (w[8]) m_rem = int'(w[LEN_LSB +: LEN_W]) + 1;
         else if (m_rem > 0) begin
            m_rem--;
            m_done = (m_rem == 0);
         end
      end
      if (we && !is_full) q.push_back({lfd, din});
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      chk("data_out",    bus.data_out,    m_dout);
      chk("data_valid",  bus.data_valid,  m_dv);
      chk("pkt_active",  bus.pkt_active,  m_rem != 0);
      chk("pkt_done",    bus.pkt_done,    m_done);
      chk("count",       bus.count,       n);
      chk("empty",       bus.empty,       n == 0);
      chk("full",        bus.full,        n == DEPTH);
      chk("almost_full", bus.almost_full, n >= DEPTH - AF_MARGIN);
      chk("ovf_err",     bus.ovf_err,     m_ovf);
      chk("udf_err",     bus.udf_err,     m_udf);
   endtask

   task automatic step(input bit we, input bit lfd, input logic [7:0] din, input bit re, input bit sr);
      bus.write_enb = we;
      bus.lfd_state = lfd;
      bus.data_in   = din;
      bus.read_enb  = re;
      soft_reset    = sr;
      model_edge(we, lfd, din, re);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic wr(input bit lfd, input logic [7:0] din);
      step(1, lfd, din, 0, 0);
   endtask

   task automatic rd();
      step(0, 0, 8'h00, 1, 0);
   endtask

   logic [7:0] exp_seq [5];

   initial begin
      resetn = 1'b0;
      soft_reset = 1'b0;
      bus.write_enb = 0; bus.lfd_state = 0; bus.data_in = '0; bus.read_enb = 0;
      model_clear();
      step(0, 0, 8'h00, 0, 0);
      step(0, 0, 8'h00, 0, 0);
      resetn = 1'b1;

      // Plan 1: one packet, header len 3, read back to back
      exp_seq[0] = 8'h0E;
      exp_seq[1] = 8'($urandom);
      exp_seq[2] = 8'($urandom);
      exp_seq[3] = 8'($urandom);
      exp_seq[4] = 8'hA5;
      for (int i = 0; i < 5; i++) wr(i == 0, exp_seq[i]);
      for (int i = 0; i < 5; i++) begin
         rd();
         chk("p1_seq",    bus.data_out,   exp_seq[i]);
         chk("p1_active", bus.pkt_active, i < 4);
         chk("p1_done",   bus.pkt_done,   i == 4);
      end
      chk("p1_count", bus.count, 0);

      // Plan 2: fill, then overflow attempt
      for (int i = 0; i < DEPTH; i++) wr(0, 8'($urandom));
      chk("p2_full", bus.full, 1);
      wr(0, 8'hFF);
      chk("p2_ovf", bus.ovf_err, 1);
      chk("p2_cnt", bus.count, DEPTH);

      // Plan 3: down to 8, then 20 cycles of simultaneous read+write, then drain
      for (int i = 0; i < 8; i++) rd();
      for (int i = 0; i < 20; i++) step(1, 0, 8'($urandom), 1, 0);
      chk("p3_cnt", bus.count, 8);
      for (int i = 0; i < 8; i++) rd();

      // Plan 4: underflow, then soft reset clears the sticky flags
      rd();
      chk("p4_udf", bus.udf_err, 1);
      step(0, 0, 8'h00, 0, 1);
      chk("p4_udf_clr", bus.udf_err, 0);

      // Plan 5: flush midway through a 10-word packet, then a fresh packet
      wr(1, 8'h20);
      for (int i = 0; i < 9; i++) wr(0, 8'($urandom));
      for (int i = 0; i < 4; i++) rd();
      step(0, 0, 8'h00, 1, 1);
      chk("p5_dout", bus.data_out, 0);
      chk("p5_act",  bus.pkt_active, 0);
      wr(1, 8'h04); wr(0, 8'h3C); wr(0, 8'h5A);
      for (int i = 0; i < 3; i++) rd();
      chk("p5_done", bus.pkt_done, 1);

      // Plan 6: len 0 packet, then a truncated len 5 packet overtaken by a len 2 header
      wr(1, 8'h00); wr(0, 8'h77);
      wr(1, 8'h14); wr(0, 8'h11); wr(0, 8'h22);
      wr(1, 8'h08); wr(0, 8'h33); wr(0, 8'h44); wr(0, 8'h99);
      rd(); rd();
      chk("p6_done0", bus.pkt_done, 1);
      for (int i = 0; i < 7; i++) rd();

      // Random traffic against the model
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 8'($urandom),
              $urandom_range(0, 2) != 0, $urandom_range(0, 79) == 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/router_pkt_fifo.md
Name: router_pkt_fifo

Overview:
Parametrised packet-aware FIFO for the router output channels. It replaces the fixed 16x8 channel FIFO with configurable data width and depth, a registered valid-qualified output, occupancy and almost-full status, and on-the-fly packet-boundary tracking driven by the header length field. It sits between the router synchroniser/FSM write side and each destination read port.

Parameters:
DATA_W, 8, payload byte width; stored word is DATA_W+1 bits: header tag plus data.
DEPTH, 16, number of entries; power of two, minimum 4.
LEN_LSB, 2, LSB position of the payload-length field inside a header word.
LEN_W, 6, width of the payload-length field; LEN_LSB+LEN_W <= DATA_W.
AF_MARGIN, 2, almost_full asserts when count >= DEPTH-AF_MARGIN.

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
soft_reset  in  1  synchronous flush of the channel (timeout from the sync block)
write_enb  in  1  write request
lfd_state  in  1  tags the word written this cycle as a packet header
data_in  in  DATA_W  write data
read_enb  in  1  read request
data_out  out  DATA_W  registered read data
data_valid  out  1  data_out holds a word popped on the previous cycle
pkt_active  out  1  a packet is partially read (header popped, parity not yet popped)
pkt_done  out  1  one-cycle pulse with data_valid of the final (parity) word
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_full  out  1  count >= DEPTH-AF_MARGIN
count  out  $clog2(DEPTH)+1  current occupancy
ovf_err  out  1  sticky: write attempted while full
udf_err  out  1  sticky: read attempted while empty

Behaviour:
- Reset: resetn low, sampled at the rising edge of clk, has priority over everything. It clears wr_ptr, rd_ptr, count, rem_cnt, data_out, data_valid, pkt_done, ovf_err and udf_err to 0. Memory contents are not cleared.
- soft_reset, when resetn is high: same clears as reset, in the same cycle. Any write or read requested that cycle is ignored. No tri-state output in any mode.
- Write accepted when write_enb && !full. mem[wr_ptr] <= {lfd_state, data_in}, and wr_ptr increments modulo DEPTH (natural wrap). The tag uses lfd_state of the same cycle; there is no delay stage.
- Read accepted when read_enb && !empty. data_out <= mem[rd_ptr][DATA_W-1:0] next cycle, data_valid=1 for that one cycle, and rd_ptr increments modulo DEPTH.
- No accepted read in a cycle: data_valid=0 next cycle and data_out holds its last value.
- Read latency is 1 cycle.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
- Write while full is rejected even if a read occurs the same cycle; the bench must not rely on pass-through.
- Read while empty is rejected even if a write occurs the same cycle.
- count: +1 on write only, -1 on read only, else hold. It never exceeds DEPTH or underflows.
- Flags are combinational from count.
- ovf_err sets on write_enb && full. udf_err sets on read_enb && empty. Both clear only on reset or soft_reset.
- Packet tracker, rem_cnt (LEN_W+1 bits), evaluated on each accepted read:
  - Popped word tag=1 (header): rem_cnt <= len+1, where len = data[LEN_LSB+LEN_W-1:LEN_LSB]. This counts payload bytes plus parity.
  - Tag=0 and rem_cnt != 0: rem_cnt decrements.
  - Tag=0 and rem_cnt == 0: hold (stray byte, no error).
- pkt_active = (rem_cnt != 0), registered and aligned with data_valid.
- pkt_done pulses in the cycle data_valid=1 for the read that takes rem_cnt from 1 to 0.
- Header with len=0: rem_cnt becomes 1; the next read (parity) produces pkt_done.
- Header popped while rem_cnt != 0 (truncated packet): rem_cnt reloads from the new header, and no pkt_done is issued for the old packet.

Test Plan:
1. Reset, then write header 0x0E (len 3), 3 payload bytes, and parity 0xA5 with lfd_state high only on the header. Then read 5 words back to back -> data_out sequence 0x0E, p0, p1, p2, 0xA5 one cycle after each read; pkt_active=1 from the header through the 4th word; pkt_done=1 only with 0xA5; count returns to 0.
2. Write 16 words (DEPTH=16) -> full=1 and almost_full from count 14. Attempt a 17th write -> count stays 16, ovf_err=1, stored data unchanged.
3. With count=8, issue simultaneous read_enb and write_enb for 20 cycles -> count stays 8 and both pointers wrap with no data corruption. Then drain 8 words -> values in FIFO order.
4. Read with empty=1 -> data_valid=0, count=0, udf_err=1. Then pulse soft_reset -> udf_err=0.
5. Midway through a 10-byte packet (4 bytes read), assert soft_reset with read_enb high -> next cycle count=0, pkt_active=0, data_valid=0, data_out=0. A fresh packet then reads correctly.
6. Header with len=0 followed by parity; then header len=5 pushed while the previous packet is truncated -> pkt_done on the parity of the first packet, and rem_cnt reloads to 6 on the second header.
